pipeline_stage: RTL and testbench

Parametrised elastic pipeline register that splits the MIPS datapath into IF/ID/EX/MEM/WB stages. It generalises the fixed single-cycle wiring to any payload width with a valid/ready handshake, synchronous flush for branch/jump squash, and an optional 2-entry skid mode that registers `in_ready`. It also carries an occupancy output and a saturating stall counter for hazard debug. One instance sits between each pair of adjacent stages.

---
 rtl/pipeline_stage_pkg.sv | 10 +
 rtl/pipeline_stage_slot.sv | 29 ++
 rtl/pipeline_stage.sv | 119 +++++++++++
 tb/tb_pipeline_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_pkg.sv
// Shared constants for the elastic pipeline register between MIPS datapath stages.
// Mode selectors for the SKID parameter and the default bubble encoding (a NOP).
package pipeline_stage_pkg;

    localparam bit PIPE_MODE_SINGLE = 1'b0;
    localparam bit PIPE_MODE_SKID   = 1'b1;

    localparam logic [31:0] PIPE_BUBBLE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipeline_stage_slot.sv
// One storage slot: payload plus valid flag with load/clear.
// A cleared or reset slot holds BUBBLE_VALUE.
module pipeline_slot #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  BUBBLE_VALUE = '0
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= BUBBLE_VALUE;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= BUBBLE_VALUE;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipeline_stage.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer,
// synchronous flush, occupancy output and saturating stall counter.
module pipeline_stage
    import pipeline_stage_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter bit                SKID         = PIPE_MODE_SKID,
    parameter logic [WIDTH-1:0]  BUBBLE_VALUE = WIDTH'(PIPE_BUBBLE_NOP),
    parameter int unsigned       COUNT_WIDTH  = 16
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             occupancy,
    input  logic                   stall_clear,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    logic             m_valid;
    logic             m_load;
    logic             m_clear;
    logic [WIDTH-1:0] m_next;
    logic             s_valid;
    logic             in_hs;
    logic             out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = m_valid && out_ready;

    pipeline_slot #(
        .WIDTH        (WIDTH),
        .BUBBLE_VALUE (BUBBLE_VALUE)
    ) u_main (
        .system_clock (system_clock),
        .reset        (reset),
        .load         (m_load),
        .clear        (m_clear),
        .load_data    (m_next),
        .valid        (m_valid),
        .data         (out_data)
    );

    if (SKID == PIPE_MODE_SINGLE) begin : g_single
        assign in_ready = !m_valid || out_ready;
        assign s_valid  = 1'b0;

        always_comb begin
            m_next  = in_data;
            m_load  = in_hs && !flush;
            m_clear = flush || (out_hs && !in_hs);
        end
    end else begin : g_skid
        logic             s_load;
        logic             s_clear;
        logic [WIDTH-1:0] s_data;
        logic             ready_q;

        pipeline_slot #(
            .WIDTH        (WIDTH),
            .BUBBLE_VALUE (BUBBLE_VALUE)
        ) u_skid (
            .system_clock (system_clock),
            .reset        (reset),
            .load         (s_load),
            .clear        (s_clear),
            .load_data    (in_data),
            .valid        (s_valid),
            .data         (s_data)
        );

        // in_ready is S's next emptiness, computed ahead so it comes straight from a flop.
        always_ff @(posedge system_clock or posedge reset) begin
            if (reset) ready_q <= 1'b1;
            else       ready_q <= !((s_valid && !s_clear) || s_load);
        end
        assign in_ready = ready_q;

        always_comb begin
            m_next  = in_data;
            m_load  = 1'b0;
            m_clear = flush;
            s_load  = 1'b0;
            s_clear = flush;
            if (!flush) begin
                if (out_hs && s_valid) begin
                    m_load  = 1'b1;
                    m_next  = s_data;
                    s_clear = 1'b1;
                end else if (out_hs) begin
                    m_load  = in_hs;
                    m_clear = !in_hs;
                end else if (in_hs) begin
                    m_load  = !m_valid;
                    s_load  = m_valid;
                end
            end
        end
    end

    assign out_valid = m_valid;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_clear) begin
            stall_count <= '0;
        end else if (m_valid && !out_ready && stall_count != '1) begin
            stall_count <= stall_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stage.sv
// Directed bench for pipeline_stage: a skid-mode and a single-register instance
// share stimulus; each scenario checks the instance it targets.
module tb_pipeline_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       stall_clear;

    logic       k_in_ready, k_out_valid;
    logic [7:0] k_out_data;
    logic [1:0] k_occ;
    logic [2:0] k_stall;

    logic        n_in_ready, n_out_valid;
    logic [7:0]  n_out_data;
    logic [1:0]  n_occ;
    logic [15:0] n_stall;

    localparam logic [7:0] K_BUBBLE = 8'h5A;
    localparam logic [7:0] N_BUBBLE = 8'hC3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stage #(
        .WIDTH        (8),
        .SKID         (1'b1),
        .BUBBLE_VALUE (K_BUBBLE),
        .COUNT_WIDTH  (3)
    ) dut_skid (
        .system_clock (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (k_in_ready),
        .in_data      (in_data),
        .out_valid    (k_out_valid),
        .out_ready    (out_ready),
        .out_data     (k_out_data),
        .occupancy    (k_occ),
        .stall_clear  (stall_clear),
        .stall_count  (k_stall)
    );

    pipeline_stage #(
        .WIDTH        (8),
        .SKID         (1'b0),
        .BUBBLE_VALUE (N_BUBBLE),
        .COUNT_WIDTH  (16)
    ) dut_single (
        .system_clock (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (n_in_ready),
        .in_data      (in_data),
        .out_valid    (n_out_valid),
        .out_ready    (out_ready),
        .out_data     (n_out_data),
        .occupancy    (n_occ),
        .stall_clear  (stall_clear),
        .stall_count  (n_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b1;
        stall_clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Reset state
        check("k_rst_valid", 32'(k_out_valid), 32'd0);
        check("k_rst_data",  32'(k_out_data),  32'(K_BUBBLE));
        check("k_rst_occ",   32'(k_occ),       32'd0);
        check("k_rst_stall", 32'(k_stall),     32'd0);
        check("k_rst_ready", 32'(k_in_ready),  32'd1);
        check("n_rst_valid", 32'(n_out_valid), 32'd0);
        check("n_rst_data",  32'(n_out_data),  32'(N_BUBBLE));
        check("n_rst_ready", 32'(n_in_ready),  32'd1);

        // Full-throughput stream 01..08
        for (int unsigned i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            check("k_stream_data",  32'(k_out_data),  i);
            check("k_stream_valid", 32'(k_out_valid), 32'd1);
            check("k_stream_ready", 32'(k_in_ready),  32'd1);
            check("n_stream_data",  32'(n_out_data),  i);
            check("n_stream_valid", 32'(n_out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("k_stream_drain", 32'(k_out_valid), 32'd0);
        check("k_drain_bubble", 32'(k_out_data),  32'(K_BUBBLE));
        check("n_stream_drain", 32'(n_out_valid), 32'd0);
        check("k_stream_stall", 32'(k_stall),     32'd0);
        check("n_stream_stall", 32'(n_stall),     32'd0);

        // Skid: downstream stall for 3 cycles
        do_reset();
        in_valid = 1'b1; in_data = 8'hA1;
        step();
        out_ready = 1'b0; in_data = 8'hA2;
        step();
        check("skid_occ2",   32'(k_occ),      32'd2);
        check("skid_rdy0",   32'(k_in_ready), 32'd0);
        check("skid_head",   32'(k_out_data), 32'hA1);
        in_data = 8'hA3;
        step();
        step();
        check("skid_occ_hold", 32'(k_occ),   32'd2);
        check("skid_stall3",   32'(k_stall), 32'd3);
        out_ready = 1'b1;
        step();
        check("skid_order2", 32'(k_out_data), 32'hA2);
        check("skid_rdy1",   32'(k_in_ready), 32'd1);
        check("skid_occ1",   32'(k_occ),      32'd1);
        step();
        check("skid_order3", 32'(k_out_data), 32'hA3);
        in_valid = 1'b0;
        step();
        check("skid_empty",  32'(k_out_valid), 32'd0);
        check("skid_stall_keep", 32'(k_stall), 32'd3);

        // Flush with both slots full and B3 offered
        do_reset();
        in_valid = 1'b1; in_data = 8'hB1;
        step();
        out_ready = 1'b0; in_data = 8'hB2;
        step();
        check("flush_pre_occ", 32'(k_occ), 32'd2);
        in_data = 8'hB3; flush = 1'b1;
        step();
        check("flush_valid", 32'(k_out_valid), 32'd0);
        check("flush_data",  32'(k_out_data),  32'(K_BUBBLE));
        check("flush_occ",   32'(k_occ),       32'd0);
        check("flush_rdy",   32'(k_in_ready),  32'd1);
        check("flush_stall", 32'(k_stall),     32'd2);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("flush_no_b3", 32'(k_out_valid), 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hB4;
        for (int unsigned i = 0; i < 2; i++) begin
            step();
            check("flush_hold_occ", 32'(k_occ), 32'd0);
            check("n_flush_hold",   32'(n_out_valid), 32'd0);
        end
        flush = 1'b0; in_valid = 1'b0;

        // Stall counter saturation and clear
        do_reset();
        in_valid = 1'b1; in_data = 8'h11;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int unsigned i = 0; i < 10; i++) step();
        check("sat_7", 32'(k_stall), 32'd7);
        check("n_stall_10", 32'(n_stall), 32'd10);
        stall_clear = 1'b1;
        step();
        check("clr_0", 32'(k_stall), 32'd0);
        stall_clear = 1'b0;
        step();
        check("resume_1", 32'(k_stall), 32'd1);
        step();
        check("resume_2", 32'(k_stall), 32'd2);

        // Asynchronous reset between edges with occupancy 2
        do_reset();
        in_valid = 1'b1; in_data = 8'hD1;
        step();
        out_ready = 1'b0; in_data = 8'hD2;
        step();
        check("arst_pre_occ", 32'(k_occ), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(k_out_valid), 32'd0);
        check("arst_data",  32'(k_out_data),  32'(K_BUBBLE));
        check("arst_occ",   32'(k_occ),       32'd0);
        check("arst_rdy",   32'(k_in_ready),  32'd1);
        check("arst_stall", 32'(k_stall),     32'd0);
        check("n_arst_occ", 32'(n_occ),       32'd0);
        step();
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hC1;
        step();
        check("post_rst_k", 32'(k_out_data), 32'hC1);
        check("post_rst_n", 32'(n_out_data), 32'hC1);
        in_valid = 1'b0;
        step();

        // Single register: combinational in_ready and bubble-free swap
        do_reset();
        in_valid = 1'b1; in_data = 8'hE1;
        step();
        out_ready = 1'b0; in_data = 8'hE2;
        #1;
        check("n_rdy_comb0", 32'(n_in_ready), 32'd0);
        step();
        check("n_hold_e1",   32'(n_out_data), 32'hE1);
        check("n_occ1",      32'(n_occ),      32'd1);
        out_ready = 1'b1;
        #1;
        check("n_rdy_comb1", 32'(n_in_ready), 32'd1);
        step();
        check("n_swap_data",  32'(n_out_data),  32'hE2);
        check("n_swap_valid", 32'(n_out_valid), 32'd1);
        check("n_swap_stall", 32'(n_stall),     32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
